// File: rtl/VX_gpu_pkg.sv
// VX_gpu_pkg: execute-unit lane indices and ex_type width shared by the issue slice
package VX_gpu_pkg;
  localparam int EX_BITS      = 2;
  localparam int EX_ALU       = 0;
  localparam int EX_LSU       = 1;
  localparam int EX_SFU       = 2;
  localparam int EX_VPU       = 3;
  localparam int NUM_EX_UNITS = 4;
endpackage

// File: rtl/vx_vdispatch_lane.sv
// vx_vdispatch_lane: 2-entry elastic FIFO with registered flags (i_push/i_data in, o_valid/o_data/i_ready out, o_full to dispatcher)
module vx_vdispatch_lane #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_full,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic [W-1:0] r_h, r_t;
  logic r_v, r_f, w_pop;
  assign w_pop   = r_v && i_ready;
  assign o_valid = r_v;
  assign o_full  = r_f;
  assign o_data  = r_h;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v <= 1'b0;
      r_f <= 1'b0;
      r_h <= '0;
      r_t <= '0;
    end else begin
      r_v <= r_f || i_push || (r_v && !w_pop);
      r_f <= r_f ? !w_pop : (r_v && i_push && !w_pop);
      if (i_push && (!r_v || (w_pop && !r_f))) r_h <= i_data;
      else if (w_pop && r_f) r_h <= r_t;
      if (i_push && r_v && !w_pop) r_t <= i_data;
    end
  end
`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(i_push && r_f))
    else $error("vx_vdispatch_lane: push into full lane");
`endif
endmodule

// File: rtl/vx_vdispatch.sv
// vx_vdispatch: routes collector beats (in_*) to per-unit lane FIFOs (out_*) with packet locking, sticky route_err and perf_stalls
module vx_vdispatch import VX_gpu_pkg::*; #(
  parameter string INSTANCE_ID = "",
  parameter int    ISSUE_ID    = 0,
  parameter int    NUM_LANES   = NUM_EX_UNITS,
  parameter int    DATAW       = 64,
  parameter int    EX_BITS     = VX_gpu_pkg::EX_BITS,
  parameter int    PERF_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATAW-1:0]           in_data,
  input  logic [EX_BITS-1:0]         in_ex_type,
  input  logic                       in_eop,
  output logic                       in_ready,
  output logic [NUM_LANES-1:0]       out_valid,
  output logic [NUM_LANES*DATAW-1:0] out_data,
  output logic [NUM_LANES-1:0]       out_eop,
  input  logic [NUM_LANES-1:0]       out_ready,
  output logic                       route_err,
  output logic [PERF_W-1:0]          perf_stalls
);
  localparam int LW = $clog2(NUM_LANES + 1);
  localparam logic [LW-1:0] LOCK_DROP = LW'(NUM_LANES);
  typedef enum logic {S_IDLE, S_OPEN} state_t;
  state_t r_state;
  logic [LW-1:0] r_lock, w_tgt;
  logic [NUM_LANES-1:0] w_full, w_push;
  logic [NUM_LANES:0] w_busy;
  logic [NUM_LANES-1:0][DATAW:0] w_q;
  logic w_legal, w_fire, w_bad, r_err;
  logic [PERF_W-1:0] r_stalls;
  assign w_legal   = int'(in_ex_type) < NUM_LANES;
  assign w_tgt     = (r_state == S_OPEN) ? r_lock : w_legal ? LW'(in_ex_type) : LOCK_DROP;
  assign w_busy    = {1'b0, w_full};
  assign in_ready  = !w_busy[w_tgt];
  assign w_fire    = in_valid && in_ready;
  assign w_bad     = (r_state == S_OPEN) ? (int'(in_ex_type) != int'(r_lock)) : !w_legal;
  assign route_err   = r_err;
  assign perf_stalls = r_stalls;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign w_push[i] = w_fire && (w_tgt == LW'(i));
    assign out_eop[i] = w_q[i][DATAW];
    assign out_data[i*DATAW +: DATAW] = w_q[i][DATAW-1:0];
    vx_vdispatch_lane #(.W(DATAW + 1)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push[i]),
      .i_data  ({in_eop, in_data}),
      .i_ready (out_ready[i]),
      .o_full  (w_full[i]),
      .o_valid (out_valid[i]),
      .o_data  (w_q[i])
    );
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_lock   <= '0;
      r_err    <= 1'b0;
      r_stalls <= '0;
    end else begin
      if (w_fire) r_state <= in_eop ? S_IDLE : S_OPEN;
      if (w_fire && r_state == S_IDLE && !in_eop) r_lock <= w_tgt;
      if (w_fire && w_bad) r_err <= 1'b1;
      r_stalls <= r_stalls + PERF_W'(in_valid && !in_ready && !(&r_stalls));
    end
  end
`ifndef SYNTHESIS
  a_hold: assert property (@(posedge clk) disable iff (reset) in_valid && !in_ready |=> $stable(in_data))
    else $error("%s(issue %0d): in_data changed while stalled", INSTANCE_ID, ISSUE_ID);
`endif
endmodule

// File: tb/tb_vx_vdispatch.sv
// tb_vx_vdispatch: table-driven check of routing, locking, back-pressure, errors and mid-packet reset
module tb_vx_vdispatch;
  localparam int NL = 4;
  localparam int DW = 16;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_eop = 1'b0;
  logic in_ready, route_err;
  logic [DW-1:0] in_data = '0;
  logic [2:0] in_ex_type = '0;
  logic [NL-1:0] out_valid, out_eop;
  logic [NL-1:0] out_ready = '1;
  logic [NL*DW-1:0] out_data;
  logic [15:0] perf_stalls;
  int n_cmp = 0, n_bad = 0;
  vx_vdispatch #(
    .INSTANCE_ID ("tb"),
    .ISSUE_ID    (0),
    .NUM_LANES   (NL),
    .DATAW       (DW),
    .EX_BITS     (3),
    .PERF_W      (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ex_type  (in_ex_type),
    .in_eop      (in_eop),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_eop     (out_eop),
    .out_ready   (out_ready),
    .route_err   (route_err),
    .perf_stalls (perf_stalls)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rs; logic v; logic [2:0] ex; logic eop; logic [15:0] d; logic [3:0] ordy;
    logic irdy; logic [3:0] ov; logic [3:0] oe; int cl; logic [15:0] cd; logic err; logic [15:0] st;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input logic rs, v, input logic [2:0] ex, input logic eop, input logic [15:0] d,
                     input logic [3:0] ordy, input logic irdy, input logic [3:0] ov, oe, input int cl,
                     input logic [15:0] cd, input logic err, input logic [15:0] st);
    vec_t r;
    r.rs = rs; r.v = v; r.ex = ex; r.eop = eop; r.d = d; r.ordy = ordy; r.irdy = irdy;
    r.ov = ov; r.oe = oe; r.cl = cl; r.cd = cd; r.err = err; r.st = st;
    tbl.push_back(r);
  endtask
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, idx, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [2:0] ex, input logic eop, input logic [15:0] d, input logic [3:0] ordy);
    in_valid = v; in_ex_type = ex; in_eop = eop; in_data = d; out_ready = ordy;
  endtask
  initial begin
    //  rs v ex eop d        ordy  irdy ov    oe    cl  cd        err st
    add(0, 1, 1, 1, 16'h1111, 4'hF, 1, 4'h0, 4'h0, -1, 16'h0000, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 4'hF, 1, 4'h2, 4'h2,  1, 16'h1111, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 4'hF, 1, 4'h0, 4'h0, -1, 16'h0000, 0, 0);
    add(0, 1, 3, 0, 16'h00A1, 4'h7, 1, 4'h0, 4'h0, -1, 16'h0000, 0, 0);
    add(0, 1, 3, 0, 16'h00A2, 4'h7, 1, 4'h8, 4'h0,  3, 16'h00A1, 0, 0);
    add(0, 1, 3, 0, 16'h00A3, 4'h7, 0, 4'h8, 4'h0,  3, 16'h00A1, 0, 0);
    add(0, 1, 3, 0, 16'h00A3, 4'h7, 0, 4'h8, 4'h0,  3, 16'h00A1, 0, 1);
    add(0, 1, 3, 0, 16'h00A3, 4'h7, 0, 4'h8, 4'h0,  3, 16'h00A1, 0, 2);
    add(0, 1, 3, 0, 16'h00A3, 4'hF, 0, 4'h8, 4'h0,  3, 16'h00A1, 0, 3);
    add(0, 1, 3, 0, 16'h00A3, 4'hF, 1, 4'h8, 4'h0,  3, 16'h00A2, 0, 4);
    add(0, 1, 3, 1, 16'h00A4, 4'hF, 1, 4'h8, 4'h0,  3, 16'h00A3, 0, 4);
    add(0, 0, 0, 0, 16'h0000, 4'hF, 1, 4'h8, 4'h8,  3, 16'h00A4, 0, 4);
    add(0, 0, 0, 0, 16'h0000, 4'hF, 1, 4'h0, 4'h0, -1, 16'h0000, 0, 4);
    add(0, 1, 3, 1, 16'h00B1, 4'h7, 1, 4'h0, 4'h0, -1, 16'h0000, 0, 4);
    add(0, 1, 3, 1, 16'h00B2, 4'h7, 1, 4'h8, 4'h8,  3, 16'h00B1, 0, 4);
    add(0, 1, 0, 0, 16'h00C1, 4'h7, 1, 4'h8, 4'h8,  3, 16'h00B1, 0, 4);
    add(0, 1, 0, 0, 16'h00C2, 4'h7, 1, 4'h9, 4'h8,  0, 16'h00C1, 0, 4);
    add(0, 1, 0, 1, 16'h00C3, 4'h7, 1, 4'h9, 4'h8,  0, 16'h00C2, 0, 4);
    add(0, 0, 0, 0, 16'h0000, 4'h7, 1, 4'h9, 4'h9,  0, 16'h00C3, 0, 4);
    add(0, 0, 0, 0, 16'h0000, 4'hF, 1, 4'h8, 4'h8,  3, 16'h00B1, 0, 4);
    add(0, 0, 0, 0, 16'h0000, 4'hF, 1, 4'h8, 4'h8,  3, 16'h00B2, 0, 4);
    add(0, 1, 2, 0, 16'h00D1, 4'hF, 1, 4'h0, 4'h0, -1, 16'h0000, 0, 4);
    add(0, 1, 0, 0, 16'h00D2, 4'hF, 1, 4'h4, 4'h0,  2, 16'h00D1, 0, 4);
    add(0, 1, 2, 1, 16'h00D3, 4'hF, 1, 4'h4, 4'h0,  2, 16'h00D2, 1, 4);
    add(0, 0, 0, 0, 16'h0000, 4'hF, 1, 4'h4, 4'h4,  2, 16'h00D3, 1, 4);
    add(0, 0, 0, 0, 16'h0000, 4'hF, 1, 4'h0, 4'h0, -1, 16'h0000, 1, 4);
    add(1, 1, 5, 0, 16'h00E1, 4'hF, 1, 4'h0, 4'h0, -1, 16'h0000, 0, 0);
    add(0, 1, 1, 0, 16'h00E2, 4'hF, 1, 4'h0, 4'h0, -1, 16'h0000, 1, 0);
    add(0, 1, 5, 1, 16'h00E3, 4'hF, 1, 4'h0, 4'h0, -1, 16'h0000, 1, 0);
    add(0, 1, 1, 1, 16'h00F1, 4'hF, 1, 4'h0, 4'h0, -1, 16'h0000, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 4'hF, 1, 4'h2, 4'h2,  1, 16'h00F1, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 4'hF, 1, 4'h0, 4'h0, -1, 16'h0000, 1, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    foreach (tbl[i]) begin
      if (tbl[i].rs) begin
        reset = 1'b1;
        #1 reset = 1'b0;
      end
      drive(tbl[i].v, tbl[i].ex, tbl[i].eop, tbl[i].d, tbl[i].ordy);
      @(negedge clk);
      chk("in_ready", i, 32'(in_ready), 32'(tbl[i].irdy));
      chk("out_valid", i, 32'(out_valid), 32'(tbl[i].ov));
      chk("out_eop", i, 32'(out_eop & out_valid), 32'(tbl[i].oe));
      if (tbl[i].cl >= 0) chk("out_data", i, 32'(out_data[tbl[i].cl*DW +: DW]), 32'(tbl[i].cd));
      chk("route_err", i, 32'(route_err), 32'(tbl[i].err));
      chk("perf_stalls", i, 32'(perf_stalls), 32'(tbl[i].st));
      @(posedge clk);
      #1;
    end
    drive(1'b1, 3'd2, 1'b0, 16'h0051, 4'hB);
    @(negedge clk);
    chk("rst_seq_b1_ready", 100, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    drive(1'b1, 3'd2, 1'b0, 16'h0052, 4'hB);
    @(negedge clk);
    chk("rst_seq_b2_valid", 101, 32'(out_valid), 32'h4);
    @(posedge clk); #1;
    drive(1'b1, 3'd2, 1'b0, 16'h0053, 4'hB);
    @(negedge clk);
    chk("rst_seq_b3_ready", 102, 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_seq_stalls", 103, 32'(perf_stalls), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_seq_valid", 104, 32'(out_valid), 32'h0);
    chk("rst_seq_err", 105, 32'(route_err), 32'd0);
    chk("rst_seq_stalls0", 106, 32'(perf_stalls), 32'd0);
    chk("rst_seq_ready", 107, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b1, 3'd1, 1'b1, 16'h0077, 4'hF);
    @(negedge clk);
    chk("rst_seq_new_ready", 108, 32'(in_ready), 32'd1);
    chk("rst_seq_new_idle", 109, 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 1'b0, 16'h0000, 4'hF);
    @(negedge clk);
    chk("rst_seq_new_valid", 110, 32'(out_valid), 32'h2);
    chk("rst_seq_new_data", 111, 32'(out_data[1*DW +: DW]), 32'h0077);
    chk("rst_seq_new_eop", 112, 32'(out_eop & out_valid), 32'h2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_seq_drained", 113, 32'(out_valid), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
